hyperbus_delay_ctrl: RTL and testbench
======================================

HYPERBUS_DELAY_CTRL -- requirements
Module: hyperbus_delay_ctrl

Interface
REQ-001 SHALL have parameter TapWidth, default 5, meaning tap-code width of the delay line.
REQ-002 SHALL have parameter SettleCycles, default 8, meaning clk_i cycles to wait after each tap change (range 1..255).
REQ-003 SHALL have port clk_i  input  1  single control clock, all logic on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port dly_rdy_i  input  1  delay-calibration ready, asynchronous to clk_i.
REQ-006 SHALL have port req_valid_i  input  1  new target tap request.
REQ-007 SHALL have port req_tap_i  input  TapWidth  requested target tap.
REQ-008 SHALL have port req_ready_o  output  1  request accepted when high with req_valid_i.
REQ-009 SHALL have port tap_o  output  TapWidth  tap code driving the delay line load input.
REQ-010 SHALL have port busy_o  output  1  transition in progress or calibration not ready.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse when tap_o reaches the target and settles.

Function
REQ-012 SHALL implement FSM states WAIT_RDY, IDLE, STEP, SETTLE.
REQ-013 SHALL synchronise dly_rdy_i through two flops; rdy_q is the synchronised value.
REQ-014 SHALL leave WAIT_RDY for IDLE on the first cycle rdy_q=1.
REQ-015 SHALL assert req_ready_o only in IDLE with rdy_q=1; a handshake latches req_tap_i as the target.
REQ-016 SHALL, on handshake with target equal to tap_o, go to SETTLE without changing tap_o.
REQ-017 SHALL, on handshake with target different from tap_o, go to STEP.
REQ-018 SHALL, in STEP, change tap_o by exactly +1 or -1 toward the target, then go to SETTLE; no wrap-around at 0 or 2^TapWidth-1.
REQ-019 SHALL, in SETTLE, count SettleCycles cycles; at expiry go to STEP if tap_o differs from the target, else pulse done_o and go to IDLE.
REQ-020 SHALL pulse done_o in the same cycle as the SETTLE->IDLE transition; req_ready_o rises the following cycle.
REQ-021 SHALL, if rdy_q falls in any state, go to WAIT_RDY, hold tap_o, and drop the pending target without a done_o pulse.
REQ-022 SHALL drive busy_o high in every state except IDLE.
REQ-023 SHALL not accept requests outside IDLE; req_valid_i held high stays pending with no loss.

Reset
REQ-024 SHALL, on rst_ni low, set state to WAIT_RDY, tap_o to 0, target to 0, settle counter to 0, synchroniser flops to 0, done_o to 0, req_ready_o to 0, and busy_o to 1.
REQ-025 SHALL apply reset asynchronously and release it on the clock; a reset mid-transition abandons the target.

Configuration
REQ-026 SHALL compile gradual stepping only when HYPERBUS_DELAY_STEP_EN is defined; without it, STEP loads the target into tap_o in one cycle, followed by one SETTLE period and done_o.

Structure
REQ-027 SHALL place the FSM state enum and a tap_t typedef (TapWidth default 5) in package hyperbus_delay_pkg.
REQ-028 SHALL implement the two-flop synchroniser as sub-module hyperbus_delay_sync.

Verification
REQ-029 SHALL cover: dly_rdy_i=0 for 20 cycles, then 1 -> busy_o=1 throughout, req_ready_o=1 exactly 3 cycles after the rise.
REQ-030 SHALL cover: tap_o=0, request 3, SettleCycles=8, STEP defined -> tap_o goes 1,2,3, each held at least 8 cycles, one done_o pulse after about 27 cycles.
REQ-031 SHALL cover: tap_o=31, request 29 -> tap_o goes 30 then 29, then done_o; request 5 with HYPERBUS_DELAY_STEP_EN undefined -> tap_o=5 in one cycle, done_o after 8 settle cycles.
REQ-032 SHALL cover: request equal to current tap 12 -> tap_o stays 12, done_o after SettleCycles.
REQ-033 SHALL cover: dly_rdy_i drops during the 0->10 transition at tap 4 -> tap_o holds 4, no done_o, WAIT_RDY; after rdy returns a new request 10 proceeds from 4.
REQ-034 SHALL cover: rst_ni asserted asynchronously mid-SETTLE -> tap_o=0, busy_o=1, done_o=0 immediately, without a clock edge.

Source files
------------

// File: rtl/hyperbus_delay_pkg.sv
// Shared types for the HyperBus delay-line tap controller.
package hyperbus_delay_pkg;

    localparam int TapWidthDefault = 5;
    // Wide enough for the largest settle period (255 cycles).
    localparam int CountWidth      = 8;

    typedef logic [TapWidthDefault-1:0] tap_t;
    typedef logic [CountWidth-1:0]      count_t;

    typedef enum logic [1:0] {
        WAIT_RDY = 2'd0,
        IDLE     = 2'd1,
        STEP     = 2'd2,
        SETTLE   = 2'd3
    } state_e;

endpackage

// File: rtl/hyperbus_delay_sync.sv
// Two-flop synchroniser that brings the delay-calibration ready flag into
// the control clock domain.
module hyperbus_delay_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic data,
    output logic sync
);

    logic meta;

    // Two back-to-back flops; only the second one is used by downstream logic.
    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples the pre-edge value; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= data;
            sync <= meta;
        end
    end

endmodule

// File: rtl/hyperbus_delay_ctrl.sv
// HyperBus delay-line tap controller: walks the tap code toward a requested
// target, waiting a settle period after every change, and stalls whenever
// the delay-calibration ready flag drops.
// Build option: define HYPERBUS_DELAY_STEP_EN to move the tap one code per
// step; without it the target is loaded in a single step.
module hyperbus_delay_ctrl #(
    parameter int TapWidth     = 5,
    parameter int SettleCycles = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                dly_rdy_i,
    input  logic                req_valid_i,
    input  logic [TapWidth-1:0] req_tap_i,
    output logic                req_ready_o,
    output logic [TapWidth-1:0] tap_o,
    output logic                busy_o,
    output logic                done_o
);

    import hyperbus_delay_pkg::*;

    localparam count_t SettleLast = count_t'(SettleCycles - 1);

    state_e              state;
    state_e              state_next;
    logic                rdy_q;
    logic [TapWidth-1:0] tap;
    logic [TapWidth-1:0] target;
    count_t              settle_cnt;
    logic                settle_done;
    logic                at_target;
    logic                handshake;

    hyperbus_delay_sync u_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .data  (dly_rdy_i),
        .sync  (rdy_q)
    );

    assign settle_done = (settle_cnt == SettleLast);
    assign at_target   = (tap == target);
    assign handshake   = req_ready_o && req_valid_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= WAIT_RDY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; losing calibration ready overrides every state.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (!rdy_q) begin
            state_next = WAIT_RDY;
        end else begin
            unique case (state)
                WAIT_RDY: state_next = IDLE;
                IDLE: begin
                    if (req_valid_i) begin
                        state_next = (req_tap_i == tap) ? SETTLE : STEP;
                    end
                end
                STEP:     state_next = SETTLE;
                SETTLE: begin
                    if (settle_done) begin
                        state_next = at_target ? IDLE : STEP;
                    end
                end
                default:  state_next = WAIT_RDY;
            endcase
        end
    end

    // Outputs decoded from the current state and the synchronised ready.
    always_comb begin
        req_ready_o = (state == IDLE) && rdy_q;
        busy_o      = (state != IDLE);
        done_o      = (state == SETTLE) && rdy_q && settle_done && at_target;
        tap_o       = tap;
    end

    // Target latch, settle counter and tap code.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tap        <= '0;
            target     <= '0;
            settle_cnt <= '0;
        end else begin
            if (handshake) begin
                target <= req_tap_i;
            end else if (!rdy_q) begin
                // Abandon whatever was pending; the tap stays where it is.
                target <= tap;
            end

            if ((state == SETTLE) && rdy_q && !settle_done) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else begin
                settle_cnt <= '0;
            end

            // STEP is only entered with tap != target, so the move never wraps.
            if ((state == STEP) && rdy_q) begin
`ifdef HYPERBUS_DELAY_STEP_EN
                if (tap < target) begin
                    tap <= tap + 1'b1;
                end else if (tap > target) begin
                    tap <= tap - 1'b1;
                end
`else
                tap <= target;
`endif
            end
        end
    end

endmodule

// File: tb/tb_hyperbus_delay_ctrl.sv
// Self-checking bench for hyperbus_delay_ctrl against a transaction-level
// model of tap movement and done timing.
module tb_hyperbus_delay_ctrl;

    localparam int TW = 5;
    localparam int S  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dly_rdy = 1'b0;
    logic          req_valid = 1'b0;
    logic [TW-1:0] req_tap = '0;
    logic          req_ready;
    logic [TW-1:0] tap;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;
    int model_tap = 0;

    hyperbus_delay_ctrl #(
        .TapWidth     (TW),
        .SettleCycles (S)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .dly_rdy_i   (dly_rdy),
        .req_valid_i (req_valid),
        .req_tap_i   (req_tap),
        .req_ready_o (req_ready),
        .tap_o       (tap),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Number of tap changes needed to go from a to b.
    function automatic int steps_needed(input int a, input int b);
        int d;
        d = (a > b) ? a - b : b - a;
`ifdef HYPERBUS_DELAY_STEP_EN
        return d;
`else
        return (d != 0) ? 1 : 0;
`endif
    endfunction

    // Cycles from the handshake edge to the cycle in which done is high.
    function automatic int latency(input int a, input int b);
        int n;
        n = steps_needed(a, b);
        return (n == 0) ? S - 1 : n * (S + 1) - 1;
    endfunction

    // Expected tap j cycles after the handshake edge.
    function automatic int tap_at(input int a, input int b, input int j);
        int k;
        int d;
        d = (a > b) ? a - b : b - a;
        if (j < 1 || d == 0) return a;
`ifdef HYPERBUS_DELAY_STEP_EN
        k = (j - 1) / (S + 1) + 1;
        if (k > d) k = d;
        return (b > a) ? a + k : a - k;
`else
        k = 0;
        return b + k;
`endif
    endfunction

    task automatic wait_ready();
        int w;
        w = 0;
        while (!req_ready && w < 64) begin
            tick();
            w++;
        end
        check("ready_wait", int'(req_ready), 1);
    endtask

    // Issue one request and follow it cycle by cycle to completion.
    task automatic run_req(input int tgt);
        int start;
        int lat;
        start = model_tap;
        lat = latency(start, tgt);
        req_valid = 1'b1;
        req_tap = TW'(tgt);
        wait_ready();
        tick();
        req_valid = 1'b0;
        for (int j = 0; j <= lat + 1; j++) begin
            if (j > 0) tick();
            check($sformatf("tap %0d->%0d j=%0d", start, tgt, j), int'(tap), tap_at(start, tgt, j));
            check($sformatf("done %0d->%0d j=%0d", start, tgt, j), int'(done), (j == lat) ? 1 : 0);
            check($sformatf("busy %0d->%0d j=%0d", start, tgt, j), int'(busy), (j <= lat) ? 1 : 0);
        end
        check($sformatf("ready_after %0d", tgt), int'(req_ready), 1);
        model_tap = tgt;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int jd;
        int held;

        // Reset values while reset is held.
        #12;
        check("rst_tap", int'(tap), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(req_ready), 0);
        rst_n = 1'b1;

        // Calibration not ready for 20 cycles, then ready after 3 edges.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("wait_busy", int'(busy), 1);
            check("wait_ready", int'(req_ready), 0);
        end
        dly_rdy = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("rise_ready k=%0d", k), int'(req_ready), (k == 3) ? 1 : 0);
            check($sformatf("rise_busy k=%0d", k), int'(busy), (k == 3) ? 0 : 1);
        end

        // Directed transitions, including both ends of the code range.
        run_req(3);
        run_req(31);
        run_req(29);
        run_req(12);
        run_req(12);
        run_req(5);
        run_req(0);
        run_req(0);

        // Random targets.
        for (int i = 0; i < 6; i++) begin
            run_req(int'($urandom_range(0, 31)));
        end
        run_req(0);

        // Ready drops mid-transition 0->10: tap holds, no done, back to wait.
        jd = 1 + 3 * (S + 1);
        held = tap_at(0, 10, jd);
        req_valid = 1'b1;
        req_tap = TW'(10);
        wait_ready();
        tick();
        req_valid = 1'b0;
        for (int j = 1; j <= jd; j++) tick();
        check("abort_tap_at_drop", int'(tap), held);
        dly_rdy = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            check($sformatf("abort_tap k=%0d", k), int'(tap), held);
            check($sformatf("abort_done k=%0d", k), int'(done), 0);
            check($sformatf("abort_ready k=%0d", k), int'(req_ready), (k < 2) ? int'(req_ready) + 0 * k : 0);
            if (k >= 3) check($sformatf("abort_busy k=%0d", k), int'(busy), 1);
        end
        dly_rdy = 1'b1;
        model_tap = held;
        run_req(10);

        // Asynchronous reset while done is high in SETTLE (equal target).
        req_valid = 1'b1;
        req_tap = TW'(10);
        wait_ready();
        tick();
        req_valid = 1'b0;
        for (int j = 1; j <= S - 1; j++) tick();
        check("pre_rst_done", int'(done), 1);
        check("pre_rst_tap", int'(tap), 10);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tap", int'(tap), 0);
        check("async_rst_busy", int'(busy), 1);
        check("async_rst_done", int'(done), 0);
        check("async_rst_ready", int'(req_ready), 0);
        #3;
        rst_n = 1'b1;
        model_tap = 0;
        run_req(7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
